eth_recv: RTL and testbench
===========================

// Module: eth_recv
// PURPOSE
//  Receive-side consumer of the 10G MAC RX AXI-Stream (clk156 domain). Parses Ethernet/IPv4/UDP
//  headers, filters on dst MAC / ethertype / protocol / dst IP / UDP port, and forwards the
//  realigned UDP payload (starts at frame byte 42) to a downstream FIFO. Keeps RX statistics.
// PARAMETERS
//  CNT_W    32  width of each statistics counter (wraps)
// PORTS
//  clk156            in   1   core clock (MAC coreclk_out)
//  aresetn           in   1   asynchronous active-low reset
//  s_axis_rx_tvalid  in   1   MAC RX beat valid (no tready: MAC cannot stall)
//  s_axis_rx_tdata   in   64  lane k = tdata[8k+7:8k] = wire byte 8*beat+k
//  s_axis_rx_tkeep   in   8   contiguous from lane 0; all 1 except on tlast beat
//  s_axis_rx_tlast   in   1   last beat of frame (FCS already stripped)
//  s_axis_rx_tuser   in   1   on tlast: 1 = frame good, 0 = MAC error
//  cfg_mac           in   48  own MAC, cfg_mac[47:40] = first wire byte
//  cfg_ip            in   32  own IPv4 address, network order
//  cfg_udp_port      in   16  accepted UDP dst port
//  cfg_promisc       in   1   1 = skip dst MAC and dst IP checks
//  clr_stats         in   1   sync pulse: zero all counters
//  m_axis_tvalid     out  1   payload beat valid (downstream must always accept)
//  m_axis_tdata      out  64  payload bytes, lane 0 first
//  m_axis_tkeep      out  8   contiguous from lane 0
//  m_axis_tlast      out  1   last payload beat
//  m_axis_tuser      out  1   on tlast: 1 = discard frame (MAC error or checksum fail)
//  m_udp_len         out  16  UDP length field of current frame, valid from first payload beat
//  stat_frames / stat_accepted / stat_filtered / stat_runt / stat_err  out CNT_W each
// BEHAVIOUR
//  - Reset: all m_axis_* 0, m_udp_len 0, counters 0, FSM in IDLE. Mid-frame reset abandons frame.
//  - Only beats with s_axis_rx_tvalid=1 advance state; tvalid gaps are legal anywhere.
//  - FSM: IDLE (beat 0) -> HDR (beats 1..4, beat counter) -> PAYLOAD or DROP; tlast -> IDLE.
//    Beat 4 (bytes 32..39) completes the decision: dst MAC==cfg_mac or ff:ff:ff:ff:ff:ff,
//    ethertype 0x0800, ver/IHL 0x45, proto 0x11, dst IP==cfg_ip, UDP dst port==cfg_udp_port.
//    Fail -> DROP (discard to tlast, stat_filtered++). Pass -> PAYLOAD.
//  - tlast in beats 0..4, or in beat 5 with tkeep<=8'h03 (no payload): stat_runt++, no output.
//  - Realign: out beat = {cur lanes 1:0, prev lanes 7:2}; first output on beat 6; latency 1 clk
//    from input beat. Last input beat with n valid lanes: n<=2 -> that out beat is tlast with
//    6+n bytes; n>2 -> out beat with 8 bytes, then a flush beat (tlast, n-2 bytes) next clock.
//    Flush is output-side only: it never blocks the input, so beat 0 of the next frame may be
//    parsed in the same cycle the flush beat is emitted.
//  - tlast with tuser=0: stat_err++ and m_axis_tuser=1 if payload was forwarded; counted once,
//    error takes precedence over filtered/runt. Good accepted frame: stat_accepted++.
//  - stat_frames++ on every input tlast. Counters wrap at 2^CNT_W. clr_stats beats any increment.
// CONFIGURATION
//  - ETH_RECV_CKSUM_EN defined: IPv4 header checksum (bytes 14..33, one's-complement sum of 10
//    words, expects 16'hFFFF) accumulated over beats 1..4 as part of the beat-4 decision;
//    mismatch -> DROP, stat_filtered++.
//  - Not defined: checksum ignored, no adder logic synthesised.
// STRUCTURE
//  - eth_pkg: ETHERTYPE_IPV4, IP_PROTO_UDP, HDR_BEATS=5, PAYLOAD_LANE=2, rx_state_t enum.
//  - Sub-module eth_recv_realign: prev-beat register, lane shift, flush generation.
//  - Top: header FSM, field capture/compare, optional checksum, counters.
// TESTING
//  - cfg_mac 00:11:22:33:44:55, cfg_ip 10.0.0.1, port 3776; 64-byte UDP frame, tuser=1 ->
//    22 payload bytes over 3 out beats (tkeep ff,ff,3f), tlast on 3rd, stat_accepted=1.
//  - Same frame with dst port 3777 -> no m_axis_tvalid, stat_filtered=1; broadcast MAC and
//    cfg_promisc=1 with foreign MAC both accepted.
//  - Frame ending on tkeep=8'h1f -> extra flush beat tkeep=8'h07; back-to-back next frame beat 0
//    in flush cycle parsed and forwarded correctly.
//  - 40-byte frame -> stat_runt=1, no output; frame with tuser=0 -> m_axis_tuser=1 on tlast,
//    stat_err=1, stat_accepted unchanged.
//  - Random tvalid gaps (50%) over 1000 frames -> output byte stream identical to gap-free run.
//  - ETH_RECV_CKSUM_EN: corrupted header checksum -> dropped, stat_filtered++; without the
//    macro the same frame is accepted. aresetn pulse mid-payload -> outputs 0, next frame clean.

Source files
------------

// File: rtl/eth_recv_pkg.sv
// rtl/eth_recv_pkg.sv - shared constants, state type and header field helpers for eth_recv
package eth_recv_pkg;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam int          HDR_BEATS      = 5;
   localparam int          PAYLOAD_LANE   = 2;
   localparam int          PREV_W         = 64 - 8 * PAYLOAD_LANE;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP} rx_state_t;

   // Network-order 16-bit field starting at lane k (lane k is the high byte)
   function automatic logic [15:0] be16(input logic [63:0] d, input int k);
      return {d[8*k +: 8], d[8*k+8 +: 8]};
   endfunction

   function automatic logic [17:0] sum4(input logic [63:0] d);
      return 18'(be16(d, 0)) + 18'(be16(d, 2)) + 18'(be16(d, 4)) + 18'(be16(d, 6));
   endfunction

   function automatic logic [7:0] keep_of(input logic [3:0] n);
      return 8'hFF >> (4'd8 - n);
   endfunction
endpackage

// File: rtl/eth_recv_if.sv
// rtl/eth_recv_if.sv - 64-bit stream bundle used for the MAC RX input and the payload output
interface eth_recv_if;
   logic        tvalid;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser);
   modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/eth_recv_realign.sv
// rtl/eth_recv_realign.sv - shifts payload from frame byte 42 to lane 0 and emits the trailing flush beat
module eth_recv_realign
   import eth_recv_pkg::*;
(
   input  logic        clk156,
   input  logic        aresetn,
   input  logic        i_vld,
   input  logic        i_first,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_keep,
   input  logic        i_last,
   input  logic        i_user,
   eth_recv_if.master  m_axis
);
   logic [PREV_W-1:0] r_prev;
   logic              r_flush;
   logic [7:0]        r_flush_keep;
   logic              r_flush_user;
   logic              r_tvalid;
   logic [63:0]       r_tdata;
   logic [7:0]        r_tkeep;
   logic              r_tlast;
   logic              r_tuser;
   logic [3:0]        w_n;

   assign w_n = 4'($countones(i_keep));

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         r_prev       <= '0;
         r_flush      <= 1'b0;
         r_flush_keep <= '0;
         r_flush_user <= 1'b0;
         r_tvalid     <= 1'b0;
         r_tdata      <= '0;
         r_tkeep      <= '0;
         r_tlast      <= 1'b0;
         r_tuser      <= 1'b0;
      end else begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
         // The flush slot never collides with a payload beat: a new frame needs five header beats first
         if (r_flush) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {16'h0, r_prev};
            r_tkeep  <= r_flush_keep;
            r_tlast  <= 1'b1;
            r_tuser  <= r_flush_user;
            r_flush  <= 1'b0;
         end
         if (i_vld) begin
            r_prev <= i_data[63:8*PAYLOAD_LANE];
            if (i_first) begin
               if (i_last) begin
                  r_tvalid <= 1'b1;
                  r_tdata  <= {16'h0, i_data[63:8*PAYLOAD_LANE]};
                  r_tkeep  <= keep_of(w_n - 4'd2);
                  r_tlast  <= 1'b1;
                  r_tuser  <= ~i_user;
               end
            end else begin
               r_tvalid <= 1'b1;
               r_tdata  <= {i_data[8*PAYLOAD_LANE-1:0], r_prev};
               if (i_last && !i_keep[PAYLOAD_LANE]) begin
                  r_tkeep <= keep_of(w_n + 4'd6);
                  r_tlast <= 1'b1;
                  r_tuser <= ~i_user;
               end else begin
                  r_tkeep <= 8'hFF;
               end
               if (i_last && i_keep[PAYLOAD_LANE]) begin
                  r_flush      <= 1'b1;
                  r_flush_keep <= keep_of(w_n - 4'd2);
                  r_flush_user <= ~i_user;
               end
            end
         end
      end
   end

   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tkeep  = r_tkeep;
   assign m_axis.tlast  = r_tlast;
   assign m_axis.tuser  = r_tuser;
endmodule

// File: rtl/eth_recv.sv
// rtl/eth_recv.sv - Ethernet/IPv4/UDP receive parser, filter, payload forwarder and RX statistics.
// Define ETH_RECV_CKSUM_EN to add the IPv4 header checksum to the accept decision.
module eth_recv
   import eth_recv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk156,
   input  logic             aresetn,
   eth_recv_if.slave        s_axis_rx,
   input  logic [47:0]      cfg_mac,
   input  logic [31:0]      cfg_ip,
   input  logic [15:0]      cfg_udp_port,
   input  logic             cfg_promisc,
   input  logic             clr_stats,
   eth_recv_if.master       m_axis,
   output logic [15:0]      m_udp_len,
   output logic [CNT_W-1:0] stat_frames,
   output logic [CNT_W-1:0] stat_accepted,
   output logic [CNT_W-1:0] stat_filtered,
   output logic [CNT_W-1:0] stat_runt,
   output logic [CNT_W-1:0] stat_err
);
   rx_state_t        r_state, w_next;
   logic [2:0]       r_beat;
   logic             r_ok;
   logic [15:0]      r_udp_len;
   logic [CNT_W-1:0] r_frames, r_accepted, r_filtered, r_runt, r_err;
   logic [63:0]      w_d;
   logic             w_vld, w_eof, w_beat4, w_first, w_short5, w_runt;
   logic             w_mac_ok, w_pass, w_cksum_ok, w_pl_vld;

   assign w_d      = s_axis_rx.tdata;
   assign w_vld    = s_axis_rx.tvalid;
   assign w_eof    = w_vld && s_axis_rx.tlast;
   assign w_beat4  = (r_state == ST_HDR) && (r_beat == 3'(HDR_BEATS - 1));
   assign w_first  = (r_beat == 3'(HDR_BEATS));
   assign w_short5 = w_first && !s_axis_rx.tkeep[PAYLOAD_LANE];
   assign w_runt   = (r_state == ST_IDLE) || (r_state == ST_HDR) || w_short5;
   assign w_mac_ok = cfg_promisc || ({be16(w_d, 0), be16(w_d, 2), be16(w_d, 4)} == cfg_mac) ||
                     ({be16(w_d, 0), be16(w_d, 2), be16(w_d, 4)} == 48'hFFFF_FFFF_FFFF);
   assign w_pass   = r_ok && (cfg_promisc || (be16(w_d, 0) == cfg_ip[15:0])) &&
                     (be16(w_d, 4) == cfg_udp_port) && w_cksum_ok;
   assign w_pl_vld = w_vld && (r_state == ST_PAYLOAD) && !(s_axis_rx.tlast && w_short5);

`ifdef ETH_RECV_CKSUM_EN
   logic [19:0] r_sum;
   logic [19:0] w_sum_tot;
   logic [16:0] w_fold1;
   logic [15:0] w_fold2;

   // Header words: lanes 6-7 of beat 1, all of beats 2-3, lanes 0-1 of beat 4
   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         r_sum <= '0;
      end else if (w_vld && (r_state == ST_HDR)) begin
         if (r_beat == 3'd1) r_sum <= 20'(be16(w_d, 6));
         else                r_sum <= r_sum + 20'(sum4(w_d));
      end
   end

   assign w_sum_tot  = r_sum + 20'(be16(w_d, 0));
   assign w_fold1    = 17'(w_sum_tot[15:0]) + 17'(w_sum_tot[19:16]);
   assign w_fold2    = w_fold1[15:0] + 16'(w_fold1[16]);
   assign w_cksum_ok = (w_fold2 == 16'hFFFF);
`else
   assign w_cksum_ok = 1'b1;
`endif

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_vld) begin
         case (r_state)
            ST_IDLE: if (!s_axis_rx.tlast) w_next = ST_HDR;
            ST_HDR: begin
               if (s_axis_rx.tlast) w_next = ST_IDLE;
               else if (w_beat4)    w_next = w_pass ? ST_PAYLOAD : ST_DROP;
            end
            default: if (s_axis_rx.tlast) w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         r_beat    <= '0;
         r_ok      <= 1'b0;
         r_udp_len <= '0;
      end else if (w_vld) begin
         if (r_state == ST_IDLE) begin
            r_beat <= 3'd1;
            r_ok   <= w_mac_ok;
         end else begin
            if (r_beat != 3'(HDR_BEATS + 1)) r_beat <= r_beat + 3'd1;
            if (r_state == ST_HDR) begin
               case (r_beat)
                  3'd1:    r_ok <= r_ok && (be16(w_d, 4) == ETHERTYPE_IPV4) && (w_d[55:48] == IP_VER_IHL);
                  3'd2:    r_ok <= r_ok && (w_d[63:56] == IP_PROTO_UDP);
                  3'd3:    r_ok <= r_ok && (cfg_promisc || (be16(w_d, 6) == cfg_ip[31:16]));
                  default: r_udp_len <= be16(w_d, 6);
               endcase
            end
         end
      end
   end

   // Each frame lands in exactly one class at tlast; MAC error outranks everything
   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn || clr_stats) begin
         if (!aresetn || clr_stats) begin
            r_frames   <= '0;
            r_accepted <= '0;
            r_filtered <= '0;
            r_runt     <= '0;
            r_err      <= '0;
         end
      end else if (w_eof) begin
         r_frames <= r_frames + CNT_W'(1);
         if (!s_axis_rx.tuser)         r_err      <= r_err + CNT_W'(1);
         else if (w_runt)              r_runt     <= r_runt + CNT_W'(1);
         else if (r_state == ST_DROP)  r_filtered <= r_filtered + CNT_W'(1);
         else                          r_accepted <= r_accepted + CNT_W'(1);
      end
   end

   eth_recv_realign u_realign (
      .clk156  (clk156),
      .aresetn (aresetn),
      .i_vld   (w_pl_vld),
      .i_first (w_first),
      .i_data  (w_d),
      .i_keep  (s_axis_rx.tkeep),
      .i_last  (s_axis_rx.tlast),
      .i_user  (s_axis_rx.tuser),
      .m_axis  (m_axis)
   );

   assign m_udp_len     = r_udp_len;
   assign stat_frames   = r_frames;
   assign stat_accepted = r_accepted;
   assign stat_filtered = r_filtered;
   assign stat_runt     = r_runt;
   assign stat_err      = r_err;
endmodule

// File: tb/tb_eth_recv.sv
// tb/tb_eth_recv.sv - scoreboard bench for eth_recv: filtering, realign, flush, runt, error, gaps, reset
module tb_eth_recv;
   localparam logic [47:0] CFG_MAC  = 48'h00_11_22_33_44_55;
   localparam logic [31:0] CFG_IP   = 32'h0A_00_00_01;
   localparam logic [15:0] CFG_PORT = 16'd3776;
   localparam int C_ACC = 0, C_FILT = 1, C_RUNT = 2, C_ERR = 3;

   logic        clk156 = 1'b0;
   logic        aresetn;
   logic [47:0] cfg_mac;
   logic [31:0] cfg_ip;
   logic [15:0] cfg_udp_port;
   logic        cfg_promisc;
   logic        clr_stats;
   logic [15:0] m_udp_len;
   logic [31:0] stat_frames, stat_accepted, stat_filtered, stat_runt, stat_err;

   eth_recv_if s_rx ();
   eth_recv_if m_ax ();

   eth_recv dut (
      .clk156        (clk156),
      .aresetn       (aresetn),
      .s_axis_rx     (s_rx),
      .cfg_mac       (cfg_mac),
      .cfg_ip        (cfg_ip),
      .cfg_udp_port  (cfg_udp_port),
      .cfg_promisc   (cfg_promisc),
      .clr_stats     (clr_stats),
      .m_axis        (m_ax),
      .m_udp_len     (m_udp_len),
      .stat_frames   (stat_frames),
      .stat_accepted (stat_accepted),
      .stat_filtered (stat_filtered),
      .stat_runt     (stat_runt),
      .stat_err      (stat_err)
   );

   always #5 clk156 = ~clk156;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } exp_beat_t;

   exp_beat_t   sb[$];
   logic [7:0]  fb[0:255];
   int          flen;
   int          n_cmp = 0, n_bad = 0;
   int          e_frames = 0, e_acc = 0, e_filt = 0, e_runt = 0, e_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk156) begin
      if (aresetn === 1'b1 && m_ax.tvalid === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("unexpected_beat", {63'd0, m_ax.tvalid}, 64'd0);
         end else begin
            exp_beat_t   e;
            logic [63:0] m;
            e = sb.pop_front();
            for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{e.k[j]}};
            check_val("tdata", m_ax.tdata & m, e.d & m);
            check_val("tkeep", 64'(m_ax.tkeep), 64'(e.k));
            check_val("tlast", 64'(m_ax.tlast), 64'(e.l));
            if (e.l) check_val("tuser", 64'(m_ax.tuser), 64'(e.u));
         end
      end
   end

   task automatic build(input logic [47:0] dmac, input logic [15:0] dport, input int len, input bit bad_ck);
      int          s;
      logic [15:0] ck;
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         fb[i]     = dmac[8*(5-i) +: 8];
         fb[6 + i] = (i == 5) ? 8'h99 : ((i == 0) ? 8'h02 : 8'h00);
      end
      {fb[12], fb[13], fb[14], fb[15]} = 32'h0800_4500;
      {fb[16], fb[17]} = 16'(len - 14);
      {fb[18], fb[19], fb[20], fb[21]} = 32'h1234_4000;
      {fb[22], fb[23], fb[24], fb[25]} = 32'h4011_0000;
      {fb[26], fb[27], fb[28], fb[29]} = 32'h0A00_0002;
      {fb[30], fb[31], fb[32], fb[33]} = CFG_IP;
      {fb[34], fb[35]} = 16'h1000;
      {fb[36], fb[37]} = dport;
      {fb[38], fb[39]} = 16'(len - 34);
      {fb[40], fb[41]} = 16'h0000;
      s = 0;
      for (int i = 14; i < 34; i += 2) s += int'({fb[i], fb[i+1]});
      s = (s & 32'hFFFF) + (s >> 16);
      s = (s & 32'hFFFF) + (s >> 16);
      ck = ~16'(s);
      if (bad_ck) ck = ck ^ 16'h0001;
      {fb[24], fb[25]} = ck;
      flen = len;
   endtask

   task automatic expect_payload(input bit good);
      for (int i = 42; i < flen; i += 8) begin
         exp_beat_t e;
         e.d = '0;
         e.k = '0;
         for (int j = 0; j < 8; j++) begin
            if (i + j < flen) begin
               e.d[8*j +: 8] = fb[i + j];
               e.k[j]        = 1'b1;
            end
         end
         e.l = (i + 8 >= flen);
         e.u = e.l & ~good;
         sb.push_back(e);
      end
   endtask

   task automatic send_frame(input bit good, input int gap, input int max_beats);
      int nb;
      nb = (flen + 7) / 8;
      for (int b = 0; b < nb && b < max_beats; b++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            s_rx.tvalid = 1'b0;
            @(posedge clk156); #1;
         end
         s_rx.tvalid = 1'b1;
         for (int j = 0; j < 8; j++) begin
            s_rx.tdata[8*j +: 8] = (8*b + j < flen) ? fb[8*b + j] : 8'h00;
            s_rx.tkeep[j]        = (8*b + j < flen);
         end
         s_rx.tlast = (b == nb - 1);
         s_rx.tuser = (b == nb - 1) ? good : 1'b0;
         @(posedge clk156); #1;
      end
      s_rx.tvalid = 1'b0;
      s_rx.tlast  = 1'b0;
   endtask

   task automatic run(input logic [47:0] dmac, input logic [15:0] dport, input int len, input bit good,
                      input bit bad_ck, input int cls, input bit exp_out, input int gap);
      build(dmac, dport, len, bad_ck);
      if (exp_out) expect_payload(good);
      send_frame(good, gap, 99);
      e_frames++;
      case (cls)
         C_ACC:   e_acc++;
         C_FILT:  e_filt++;
         C_RUNT:  e_runt++;
         default: e_err++;
      endcase
   endtask

   task automatic idle(input int n);
      s_rx.tvalid = 1'b0;
      repeat (n) @(posedge clk156);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check_val({tag, "_frames"},   64'(stat_frames),   64'(e_frames));
      check_val({tag, "_accepted"}, 64'(stat_accepted), 64'(e_acc));
      check_val({tag, "_filtered"}, 64'(stat_filtered), 64'(e_filt));
      check_val({tag, "_runt"},     64'(stat_runt),     64'(e_runt));
      check_val({tag, "_err"},      64'(stat_err),      64'(e_err));
      check_val({tag, "_sb_drain"}, 64'(sb.size()),     64'd0);
   endtask

   initial begin
      aresetn = 1'b0;
      s_rx.tvalid = 1'b0; s_rx.tdata = '0; s_rx.tkeep = '0; s_rx.tlast = 1'b0; s_rx.tuser = 1'b0;
      cfg_mac = CFG_MAC; cfg_ip = CFG_IP; cfg_udp_port = CFG_PORT; cfg_promisc = 1'b0; clr_stats = 1'b0;
      repeat (3) @(posedge clk156);
      #1;
      check_val("rst_tvalid", 64'(m_ax.tvalid), 64'd0);
      check_val("rst_tlast", 64'(m_ax.tlast), 64'd0);
      check_val("rst_udp_len", 64'(m_udp_len), 64'd0);
      check_stats("rst");
      aresetn = 1'b1;
      idle(2);

      run(CFG_MAC, CFG_PORT, 64, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      idle(4);
      check_val("udp_len_64", 64'(m_udp_len), 64'd30);
      check_stats("basic");

      run(CFG_MAC, CFG_PORT + 16'd1, 64, 1'b1, 1'b0, C_FILT, 1'b0, 0);
      run(48'hFFFF_FFFF_FFFF, CFG_PORT, 72, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      run(48'h02_AA_BB_CC_DD_77, CFG_PORT, 64, 1'b1, 1'b0, C_FILT, 1'b0, 0);
      cfg_promisc = 1'b1;
      run(48'h02_AA_BB_CC_DD_77, CFG_PORT, 64, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      cfg_promisc = 1'b0;
      idle(4);
      check_stats("filter");

      run(CFG_MAC, CFG_PORT, 69, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      run(CFG_MAC, CFG_PORT, 64, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      run(CFG_MAC, CFG_PORT, 47, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      run(CFG_MAC, CFG_PORT, 50, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      idle(4);
      check_stats("flush");

      run(CFG_MAC, CFG_PORT, 40, 1'b1, 1'b0, C_RUNT, 1'b0, 0);
      run(CFG_MAC, CFG_PORT, 42, 1'b1, 1'b0, C_RUNT, 1'b0, 0);
      run(CFG_MAC, CFG_PORT, 64, 1'b0, 1'b0, C_ERR, 1'b1, 0);
      idle(4);
      check_stats("runt_err");

`ifdef ETH_RECV_CKSUM_EN
      run(CFG_MAC, CFG_PORT, 64, 1'b1, 1'b1, C_FILT, 1'b0, 0);
`else
      run(CFG_MAC, CFG_PORT, 64, 1'b1, 1'b1, C_ACC, 1'b1, 0);
`endif
      idle(4);
      check_stats("cksum");

      build(CFG_MAC, CFG_PORT, 80, 1'b0);
      send_frame(1'b1, 0, 6);
      aresetn = 1'b0;
      #1;
      check_val("mid_rst_tvalid", 64'(m_ax.tvalid), 64'd0);
      check_val("mid_rst_tkeep", 64'(m_ax.tkeep), 64'd0);
      check_val("mid_rst_udp_len", 64'(m_udp_len), 64'd0);
      e_frames = 0; e_acc = 0; e_filt = 0; e_runt = 0; e_err = 0;
      check_stats("mid_rst");
      @(posedge clk156); #1;
      aresetn = 1'b1;
      idle(1);
      run(CFG_MAC, CFG_PORT, 77, 1'b1, 1'b0, C_ACC, 1'b1, 0);
      idle(4);
      check_stats("post_rst");

      clr_stats = 1'b1;
      @(posedge clk156); #1;
      clr_stats = 1'b0;
      e_frames = 0; e_acc = 0; e_filt = 0; e_runt = 0; e_err = 0;
      check_stats("clr");

      for (int f = 0; f < 1000; f++) begin
         int len;
         bit pgood;
         len   = $urandom_range(120, 40);
         pgood = ($urandom_range(9) != 0);
         if (len <= 42)   run(CFG_MAC, pgood ? CFG_PORT : CFG_PORT + 16'd1, len, 1'b1, 1'b0, C_RUNT, 1'b0, 50);
         else if (!pgood) run(CFG_MAC, CFG_PORT + 16'd1, len, 1'b1, 1'b0, C_FILT, 1'b0, 50);
         else             run(CFG_MAC, CFG_PORT, len, 1'b1, 1'b0, C_ACC, 1'b1, 50);
      end
      idle(6);
      check_stats("gaps");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
